// File: rtl/bus_drvr_fifo.sv
// Per-terminal bus driver: TX and RX first-word-fall-through FIFOs
// with destination-ID filtering and saturating drop counters.
module bus_drvr_fifo #(
  parameter int pckg_sz   = 16,
  parameter int depth     = 8,
  parameter int ID_W      = 8,
  parameter int DRV_ID    = 0,
  parameter int FILTER_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [pckg_sz-1:0]           wr_data,
  output logic                         full,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  input  logic                         rd_en,
  output logic [pckg_sz-1:0]           rd_data,
  output logic                         rx_valid,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic [$clog2(depth+1)-1:0]   rx_count,
  output logic [CNT_W-1:0]             tx_drop_cnt,
  output logic [CNT_W-1:0]             rx_drop_cnt,
  output logic [CNT_W-1:0]             id_drop_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);
  localparam logic [CW-1:0] FULL_C = CW'(depth);
  localparam logic [ID_W-1:0] MY_ID = ID_W'(DRV_ID);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;

  logic tx_wr, tx_rd, tx_drop;
  logic rx_wr, rx_rd, rx_drop, id_drop;
  logic rx_full, id_ok;
  logic [ID_W-1:0] rx_id;

  // Flags decode registered occupancy only
  assign full     = (tx_count == FULL_C);
  assign pndng    = (tx_count != '0);
  assign rx_full  = (rx_count == FULL_C);
  assign rx_valid = (rx_count != '0);

  assign D_pop   = pndng    ? tx_mem[tx_rd_ptr] : '0;
  assign rd_data = rx_valid ? rx_mem[rx_rd_ptr] : '0;

  // A pop frees the slot the same edge, so a write on full is taken
  assign tx_rd   = pop && pndng;
  assign tx_wr   = wr_en && (!full || pop);
  assign tx_drop = wr_en && full && !pop;

  // ID filter has priority over the fullness check
  assign rx_id   = D_push[pckg_sz-1 -: ID_W];
  assign id_ok   = (FILTER_EN == 0) || (rx_id == MY_ID) || (rx_id == '1);
  assign rx_rd   = rd_en && rx_valid;
  assign rx_wr   = push && id_ok && (!rx_full || rd_en);
  assign rx_drop = push && id_ok && rx_full && !rd_en;
  assign id_drop = push && !id_ok;

  // Packet storage; stores are suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (reset && tx_wr) tx_mem[tx_wr_ptr] <= wr_data;
    if (reset && rx_wr) rx_mem[rx_wr_ptr] <= D_push;
  end

  // TX pointers, occupancy and drop counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      tx_drop_cnt <= '0;
    end else begin
      if (tx_wr) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_rd) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_wr, tx_rd})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
      if (tx_drop && tx_drop_cnt != '1)
        tx_drop_cnt <= tx_drop_cnt + 1'b1;
    end
  end

  // RX pointers, occupancy and both drop counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_drop_cnt <= '0;
      id_drop_cnt <= '0;
    end else begin
      if (rx_wr) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_rd) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_wr, rx_rd})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      if (rx_drop && rx_drop_cnt != '1)
        rx_drop_cnt <= rx_drop_cnt + 1'b1;
      if (id_drop && id_drop_cnt != '1)
        id_drop_cnt <= id_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_drvr_fifo.sv
// Scoreboard bench for bus_drvr_fifo: directed stimulus queues
// expected packets, a negedge monitor pops and compares them.
module tb_bus_drvr_fifo;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // depth 8, ID 2, filter on
  logic        wr_en_a, full_a, pndng_a, pop_a, push_a, rd_en_a, rx_valid_a;
  logic [15:0] wr_data_a, D_pop_a, D_push_a, rd_data_a;
  logic [3:0]  tx_count_a, rx_count_a;
  logic [15:0] tx_drop_a, rx_drop_a, id_drop_a;

  // depth 4, filter off, 2-bit counters
  logic        wr_en_b, full_b, pndng_b, pop_b, push_b, rd_en_b, rx_valid_b;
  logic [15:0] wr_data_b, D_pop_b, D_push_b, rd_data_b;
  logic [2:0]  tx_count_b, rx_count_b;
  logic [1:0]  tx_drop_b, rx_drop_b, id_drop_b;

  logic [15:0] txq_a[$];
  logic [15:0] rxq_a[$];
  logic [15:0] txq_b[$];
  logic [15:0] rxq_b[$];

  bus_drvr_fifo #(
    .pckg_sz(16), .depth(8), .ID_W(8), .DRV_ID(2),
    .FILTER_EN(1), .CNT_W(16)
  ) u_a (
    .clk(clk), .reset(reset),
    .wr_en(wr_en_a), .wr_data(wr_data_a), .full(full_a),
    .pndng(pndng_a), .D_pop(D_pop_a), .pop(pop_a),
    .push(push_a), .D_push(D_push_a), .rd_en(rd_en_a),
    .rd_data(rd_data_a), .rx_valid(rx_valid_a),
    .tx_count(tx_count_a), .rx_count(rx_count_a),
    .tx_drop_cnt(tx_drop_a), .rx_drop_cnt(rx_drop_a),
    .id_drop_cnt(id_drop_a)
  );

  bus_drvr_fifo #(
    .pckg_sz(16), .depth(4), .ID_W(8), .DRV_ID(0),
    .FILTER_EN(0), .CNT_W(2)
  ) u_b (
    .clk(clk), .reset(reset),
    .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b),
    .pndng(pndng_b), .D_pop(D_pop_b), .pop(pop_b),
    .push(push_b), .D_push(D_push_b), .rd_en(rd_en_b),
    .rd_data(rd_data_b), .rx_valid(rx_valid_b),
    .tx_count(tx_count_b), .rx_count(rx_count_b),
    .tx_drop_cnt(tx_drop_b), .rx_drop_cnt(rx_drop_b),
    .id_drop_cnt(id_drop_b)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexp(string nm, logic [15:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected no packet", nm, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed head must match the scoreboard front
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (pop_a && pndng_a) begin
        if (txq_a.size() == 0) unexp("tx_a_data", D_pop_a);
        else chk("tx_a_data", 32'(D_pop_a), 32'(txq_a.pop_front()));
      end
      if (rd_en_a && rx_valid_a) begin
        if (rxq_a.size() == 0) unexp("rx_a_data", rd_data_a);
        else chk("rx_a_data", 32'(rd_data_a), 32'(rxq_a.pop_front()));
      end
      if (pop_b && pndng_b) begin
        if (txq_b.size() == 0) unexp("tx_b_data", D_pop_b);
        else chk("tx_b_data", 32'(D_pop_b), 32'(txq_b.pop_front()));
        if (tx_count_b > 3'd4) unexp("tx_b_count_over", 16'(tx_count_b));
      end
      if (rd_en_b && rx_valid_b) begin
        if (rxq_b.size() == 0) unexp("rx_b_data", rd_data_b);
        else chk("rx_b_data", 32'(rd_data_b), 32'(rxq_b.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    {wr_en_a, pop_a, push_a, rd_en_a} = '0;
    {wr_en_b, pop_b, push_b, rd_en_b} = '0;
    wr_data_a = '0; D_push_a = '0;
    wr_data_b = '0; D_push_b = '0;
    tick();
    tick();
    chk("rst_full", 32'(full_a), 0);
    chk("rst_pndng", 32'(pndng_a), 0);
    chk("rst_rx_valid", 32'(rx_valid_a), 0);
    chk("rst_tx_count", 32'(tx_count_a), 0);
    chk("rst_id_drop", 32'(id_drop_a), 0);
    chk("rst_D_pop", 32'(D_pop_a), 0);
    reset = 1'b1;
    tick();

    // Basic TX order and one-cycle latency
    wr_en_a = 1'b1;
    wr_data_a = 16'h0311; txq_a.push_back(16'h0311);
    tick();
    chk("pndng_rise", 32'(pndng_a), 1);
    chk("D_pop_first", 32'(D_pop_a), 'h0311);
    wr_data_a = 16'h0322; txq_a.push_back(16'h0322);
    tick();
    wr_data_a = 16'h0333; txq_a.push_back(16'h0333);
    tick();
    wr_en_a = 1'b0;
    chk("tx_count3", 32'(tx_count_a), 3);
    pop_a = 1'b1;
    repeat (3) tick();
    pop_a = 1'b0;
    chk("pndng_fall", 32'(pndng_a), 0);
    chk("D_pop_empty", 32'(D_pop_a), 0);

    // TX full, drop, and write-with-pop on full
    wr_en_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data_a = 16'h1000 + 16'(i);
      txq_a.push_back(wr_data_a);
      tick();
    end
    wr_en_a = 1'b0;
    chk("tx_full", 32'(full_a), 1);
    wr_en_a = 1'b1; wr_data_a = 16'hDEAD;
    tick();
    wr_en_a = 1'b0;
    chk("tx_drop1", 32'(tx_drop_a), 1);
    chk("tx_count8", 32'(tx_count_a), 8);
    wr_en_a = 1'b1; pop_a = 1'b1; wr_data_a = 16'hAAAA;
    txq_a.push_back(16'hAAAA);
    tick();
    wr_en_a = 1'b0; pop_a = 1'b0;
    chk("tx_wrpop_full", 32'(tx_count_a), 8);
    chk("tx_drop_hold", 32'(tx_drop_a), 1);
    pop_a = 1'b1;
    repeat (8) tick();
    chk("tx_drained", 32'(tx_count_a), 0);
    tick();
    pop_a = 1'b0;
    chk("pop_empty_cnt", 32'(tx_count_a), 0);
    chk("pop_empty_drop", 32'(tx_drop_a), 1);

    // RX ID filter with broadcast
    push_a = 1'b1;
    D_push_a = 16'h0201; rxq_a.push_back(16'h0201);
    tick();
    D_push_a = 16'h0502;
    tick();
    D_push_a = 16'hFF03; rxq_a.push_back(16'hFF03);
    tick();
    push_a = 1'b0;
    chk("rx_count2", 32'(rx_count_a), 2);
    chk("id_drop1", 32'(id_drop_a), 1);
    chk("rd_data_head", 32'(rd_data_a), 'h0201);
    rd_en_a = 1'b1;
    repeat (2) tick();
    rd_en_a = 1'b0;
    chk("rx_empty", 32'(rx_valid_a), 0);
    chk("rd_data_empty", 32'(rd_data_a), 0);

    // RX full, drop, filter-before-full, push with rd_en
    push_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      D_push_a = 16'h0200 + 16'(i);
      rxq_a.push_back(D_push_a);
      tick();
    end
    D_push_a = 16'h02EE;
    tick();
    push_a = 1'b0;
    chk("rx_count8", 32'(rx_count_a), 8);
    chk("rx_drop1", 32'(rx_drop_a), 1);
    push_a = 1'b1; D_push_a = 16'h0777;
    tick();
    chk("id_before_full", 32'(id_drop_a), 2);
    chk("rx_drop_hold", 32'(rx_drop_a), 1);
    D_push_a = 16'h02BB; rd_en_a = 1'b1;
    rxq_a.push_back(16'h02BB);
    tick();
    push_a = 1'b0;
    chk("rx_rdpush_full", 32'(rx_count_a), 8);
    repeat (8) tick();
    rd_en_a = 1'b0;
    chk("rx_drained", 32'(rx_count_a), 0);

    // Depth 4: pointer wrap with paired write/pop
    wr_en_b = 1'b1;
    for (int i = 0; i < 22; i++) begin
      wr_data_b = 16'h5000 + 16'(i);
      txq_b.push_back(wr_data_b);
      pop_b = (i >= 2);
      tick();
    end
    wr_en_b = 1'b0;
    chk("wrap_count", 32'(tx_count_b), 2);
    repeat (2) tick();
    pop_b = 1'b0;
    chk("wrap_drained", 32'(tx_count_b), 0);

    // Depth 4: drop counter saturates at 3
    wr_en_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data_b = 16'h6000 + 16'(i);
      txq_b.push_back(wr_data_b);
      tick();
    end
    chk("b_full", 32'(full_b), 1);
    repeat (3) tick();
    chk("b_drop3", 32'(tx_drop_b), 3);
    tick();
    wr_en_b = 1'b0;
    chk("b_drop_sat", 32'(tx_drop_b), 3);
    pop_b = 1'b1;
    repeat (4) tick();
    pop_b = 1'b0;

    // Depth 4: filter disabled accepts foreign ID
    push_b = 1'b1; D_push_b = 16'h0502;
    rxq_b.push_back(16'h0502);
    tick();
    push_b = 1'b0;
    chk("nofilter_acc", 32'(rx_count_b), 1);
    chk("nofilter_id", 32'(id_drop_b), 0);
    rd_en_b = 1'b1;
    tick();
    rd_en_b = 1'b0;

    // Reset mid-operation with a concurrent push
    wr_en_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data_a = 16'h7000 + 16'(i);
      tick();
    end
    wr_en_a = 1'b0;
    push_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      D_push_a = 16'h0280 + 16'(i);
      tick();
    end
    chk("pre_rst_tx", 32'(tx_count_a), 5);
    chk("pre_rst_rx", 32'(rx_count_a), 3);
    reset = 1'b0;
    D_push_a = 16'h0299;
    tick();
    push_a = 1'b0;
    reset = 1'b1;
    chk("mrst_tx_count", 32'(tx_count_a), 0);
    chk("mrst_rx_count", 32'(rx_count_a), 0);
    chk("mrst_pndng", 32'(pndng_a), 0);
    chk("mrst_rx_valid", 32'(rx_valid_a), 0);
    chk("mrst_tx_drop", 32'(tx_drop_a), 0);
    chk("mrst_rx_drop", 32'(rx_drop_a), 0);
    chk("mrst_id_drop", 32'(id_drop_a), 0);
    chk("mrst_rd_data", 32'(rd_data_a), 0);
    tick();
    chk("mrst_no_push", 32'(rx_count_a), 0);

    chk("txq_a_left", txq_a.size(), 0);
    chk("rxq_a_left", rxq_a.size(), 0);
    chk("txq_b_left", txq_b.size(), 0);
    chk("rxq_b_left", rxq_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_drvr_fifo.md
Name: bus_drvr_fifo

Overview:
- Parametrised per-terminal bus interface that replaces a behavioural bench driver with synthesizable buffering between an agent and the bs_gnrtr_n_rbtr bus.
- TX FIFO feeds the bus through pndng/D_pop/pop; RX FIFO captures bus deliveries on push/D_push.
- Adds configurable depth, destination-ID filtering with broadcast, and saturating drop counters.
- One instance per bus terminal; bus side is pin-compatible with one bus port slice.

Parameters:
- pckg_sz, 16, packet width in bits; destination ID in top ID_W bits.
- depth, 8, entries per FIFO; power of two, >=2.
- ID_W, 8, destination ID field width.
- DRV_ID, 0, this terminal's ID.
- FILTER_EN, 1: drop RX packets whose ID is neither DRV_ID nor broadcast (all ones). 0: accept all packets.
- CNT_W, 16, width of the drop counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  agent enqueue request to TX.
- wr_data  in  pckg_sz  agent TX packet.
- full  out  1  TX FIFO full.
- pndng  out  1  to bus: TX FIFO non-empty.
- D_pop  out  pckg_sz  to bus: TX head packet (FWFT).
- pop  in  1  from bus: consume TX head.
- push  in  1  from bus: RX packet valid.
- D_push  in  pckg_sz  from bus: RX packet.
- rd_en  in  1  agent dequeue from RX.
- rd_data  out  pckg_sz  RX head packet (FWFT).
- rx_valid  out  1  RX FIFO non-empty.
- tx_count  out  $clog2(depth+1)  TX occupancy.
- rx_count  out  $clog2(depth+1)  RX occupancy.
- tx_drop_cnt  out  CNT_W  writes rejected while TX is full.
- rx_drop_cnt  out  CNT_W  pushes rejected while RX is full.
- id_drop_cnt  out  CNT_W  pushes rejected by the ID filter.

Behaviour:
- reset==0 at a clk edge clears pointers, counts and drop counters. After reset: full=0, pndng=0, rx_valid=0, counts=0, all drop counters=0. D_pop and rd_data read as 0 when their FIFO is empty.
- Reset asserted mid-operation discards all stored packets on that edge. Any same-cycle wr_en, push, pop or rd_en is ignored.
- Both FIFOs are first-word-fall-through, and storage is registered. A packet written on edge N is visible on D_pop/rd_data and its valid flag after edge N, i.e. 1-cycle latency.
- pop consumes the head at the edge. rd_en behaves the same way for RX.
- TX write accepted iff wr_en && (!full || pop); tx_count updates by +1, -1 or 0.
- wr_en while full and no pop: data discarded, tx_drop_cnt+1.
- Simultaneous wr_en and pop while full: both accepted, count stays at depth.
- pop or rd_en on an empty FIFO: ignored, no state change, no counter change.
- RX push: if FILTER_EN and ID not in {DRV_ID, all-ones}, the packet is dropped and id_drop_cnt+1. The ID filter is checked before fullness.
- Accepted-ID push while RX full and no rd_en: dropped, rx_drop_cnt+1. Push with rd_en while full: both accepted.
- Pointers are log2(depth) bits and wrap naturally. Full/empty derive from the count register, not from pointer equality.
- Drop counters saturate at 2^CNT_W-1 and never wrap.
- pndng = (tx_count!=0); full = (tx_count==depth); rx_valid = (rx_count!=0). All are registered-state decodes with no combinational path from inputs.
- TX and RX paths are fully independent and may be active in the same cycle.

Test Plan:
- Reset with depth=8: write 0x0311, 0x0322, 0x0333. pndng rises the cycle after the first write and D_pop=0x0311. Three pops return 0x0311, 0x0322, 0x0333 in order; pndng=0 after the last pop.
- Fill TX with 8 writes: full=1. 9th write alone gives tx_drop_cnt=1, tx_count=8. Next cycle, write 0xAAAA together with pop: tx_count stays 8 and 0xAAAA emerges 8th.
- DRV_ID=2, FILTER_EN=1: push 0x0201, 0x0502, 0xFF03. Result: rx_count=2, id_drop_cnt=1, rd_data sequence 0x0201 then 0xFF03.
- Fill RX to 8 and push one more: rx_drop_cnt=1. Push with rd_en while full: count stays 8. Pop on empty TX: no change.
- Run 20 write/pop pairs through depth=4 to cross pointer wrap three or more times: data order is preserved and counts never exceed 4.
- Assert reset with TX=5 and RX=3 entries plus a concurrent push: all counts, flags and counters are 0 the next cycle and the push is not stored.
